counter_seq: RTL

Command sequencer that sits directly upstream of the up/down counter and drives its `en`, `dn`, `load` and `data` controls. It accepts timed commands over a valid/ready handshake: load a value, count up, count down, or hold for N cycles. It then plays each command onto the counter control lines with registered, glitch-free outputs. Back-to-back commands execute with no idle cycle between them.

---
 rtl/counter_seq.sv | 83 ++++++++
 1 files changed

// File: rtl/counter_seq.sv
// counter_seq: timed command sequencer driving an up/down counter's en/dn/load/data controls.
module counter_seq #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    output logic             en,
    output logic             dn,
    output logic             load,
    output logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             aborted
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
    state_t state, state_n;
    logic [LEN_W-1:0] rem, rem_n;
    logic [1:0] op, op_n;
    logic [WIDTH-1:0] data_n;
    logic en_n, dn_n, load_n, done_n, aborted_n, run_n, accept;
    assign cmd_ready = !rst && (state == IDLE || (rem == ONE && !abort));
    assign accept = cmd_valid && cmd_ready;
    assign busy = state == RUN;
    // Outputs are computed from the next state so every strobe comes straight from a flop.
    always_comb begin
        state_n = state;
        rem_n = rem;
        op_n = op;
        data_n = data;
        aborted_n = 1'b0;
        if (accept) begin
            state_n = RUN;
            op_n = cmd_op;
            rem_n = (cmd_op == OP_LOAD || cmd_len == '0) ? ONE : cmd_len;
            data_n = cmd_op == OP_LOAD ? cmd_arg : data;
        end else if (state == RUN && abort) begin
            state_n = IDLE;
            rem_n = '0;
            aborted_n = 1'b1;
        end else if (state == RUN) begin
            rem_n = rem - ONE;
            state_n = rem == ONE ? IDLE : RUN;
        end
        run_n = state_n == RUN;
        load_n = run_n && op_n == OP_LOAD;
        en_n = run_n && ^op_n;
        dn_n = run_n && op_n == OP_DOWN;
        done_n = run_n && rem_n == ONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem <= '0;
            op <= '0;
            data <= '0;
            en <= 1'b0;
            dn <= 1'b0;
            load <= 1'b0;
            done <= 1'b0;
            aborted <= 1'b0;
        end else begin
            state <= state_n;
            rem <= rem_n;
            op <= op_n;
            data <= data_n;
            en <= en_n;
            dn <= dn_n;
            load <= load_n;
            done <= done_n;
            aborted <= aborted_n;
        end
    end
endmodule
